switch_debouncer: RTL and testbench
===================================

Name: switch_debouncer

Overview:
- Input-conditioning stage directly upstream of the cpu core's 4-bit `switch` input port.
- Takes raw, asynchronous, bouncing board switches and synchronises them into the clk domain.
- Filters each bit independently.
- Drives a clean, stable switch bus that the cpu's IN A / IN B instructions read, plus a one-cycle change strobe.

Parameters:
- WIDTH, 4, number of switch bits; matches the cpu switch bus.
- SYNC_STAGES, 2, flip-flop synchroniser depth per bit; legal range 2..4.
- STABLE_CYCLES, 16, consecutive cycles a synchronised bit must differ from its output before the output takes it; legal range 1..65535.
- RESET_VAL, 0, WIDTH-bit value driven on `switch` during and after reset.

Ports:
- clk  input  1  system clock; all state on rising edge.
- n_rst  input  1  reset, asynchronous, active-low; clears all state immediately.
- sw_raw  input  WIDTH  raw asynchronous switch levels; may glitch at any time.
- switch  output  WIDTH  debounced switch value; connects to cpu `switch`.
- changed  output  1  one-cycle pulse: `switch` updated on the previous edge.

Behaviour:
- Reset, while n_rst is low, asynchronously:
  - every synchroniser flop is cleared to the matching RESET_VAL bit;
  - switch = RESET_VAL;
  - changed = 0;
  - all counters = 0.
- Synchroniser:
  - each bit passes through a SYNC_STAGES flop chain;
  - s[i] is the last stage;
  - no combinational path from sw_raw to any output.
- Per-bit filter FSM, two states:
  - IDLE (s[i]==switch[i], count=0);
  - SETTLING (s[i]!=switch[i]).
- Counter width is $clog2(STABLE_CYCLES) with a minimum of 1.
- Transitions at each clk edge:
  - IDLE, s[i]==switch[i]: stay, count=0.
  - IDLE, s[i]!=switch[i], STABLE_CYCLES==1: switch[i]<=s[i], stay IDLE.
  - IDLE, s[i]!=switch[i], STABLE_CYCLES>1: go SETTLING, count<=1.
  - SETTLING, s[i]==switch[i] (bounce back): go IDLE, count<=0, output unchanged.
  - SETTLING, s[i]!=switch[i], count<STABLE_CYCLES-1: count<=count+1.
  - SETTLING, s[i]!=switch[i], count==STABLE_CYCLES-1: switch[i]<=s[i], count<=0, go IDLE.
- Latency:
  - sw_raw level held stable, first sampled at edge 1 → switch bit updates at edge SYNC_STAGES+STABLE_CYCLES;
  - defaults give 18 edges.
- A bounce restarts the count; latency is measured from the first sampling edge of the final level.
- changed:
  - registered;
  - high for exactly one cycle after any edge where at least one switch bit changed;
  - multiple bits updating on the same edge produce a single pulse;
  - updates on consecutive edges produce back-to-back pulses.
- No wrap-around: the counter never exceeds STABLE_CYCLES-1.
- Reset asserted mid-settle:
  - discards all progress;
  - after release, filtering restarts from RESET_VAL.
- The output never takes a value that the synchronised bit has not held for STABLE_CYCLES consecutive cycles.

Optional Feature:
- Macro: SWITCH_DEBOUNCE_EDGE_EN.
- Defined:
  - adds output port sw_rise, WIDTH bits;
  - sw_rise[i] is a one-cycle registered pulse, concurrent with changed, when switch[i] goes 0→1;
  - reset value 0.
- Undefined:
  - port and its logic are absent;
  - all other behaviour is identical.

Test Plan (bench uses WIDTH=4, SYNC_STAGES=2, STABLE_CYCLES=4, RESET_VAL=0, so latency=6):
- Reset hold: n_rst=0, sw_raw=4'hF for 10 cycles → switch=4'h0, changed=0 throughout. Release n_rst → switch=4'hF at edge 6 after release, changed pulses once.
- Clean step: sw_raw 4'h0→4'h5, held → switch=4'h5 after edge 6, changed high exactly one cycle, no further pulses over 50 cycles.
- Bounce: sw_raw[0] sequence 1,0,1,0 at 2-cycle spacing, then held 1 → switch[0] stays 0 through the bounces, becomes 1 exactly 6 edges after the final 0→1, single changed pulse.
- Independent bits: sw_raw[0]=1 sampled at edge 1, sw_raw[2]=1 sampled at edge 3 → switch=4'h1 at edge 6, 4'h5 at edge 8, two separate changed pulses.
- Reset mid-settle: sw_raw 0→4'h3, assert n_rst after 3 edges → switch=4'h0 immediately with no clock edge, changed=0. Release with sw_raw=4'h3 → switch=4'h3 at edge 6 after release.
- SWITCH_DEBOUNCE_EDGE_EN defined: switch settles 4'h3, then sw_raw changes to 4'h6 → sw_rise=4'b0100 for one cycle, concurrent with changed; no pulse on bit 1 (unchanged) or bit 0 (falling).

Source files
------------

// File: rtl/switch_debouncer.sv
// ============================================================================
// switch_debouncer : synchronises and debounces raw board switches per bit.
// Optional sw_rise output enabled by defining SWITCH_DEBOUNCE_EDGE_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module switch_debouncer #(
  parameter int               WIDTH         = 4,
  parameter int               SYNC_STAGES   = 2,
  parameter int               STABLE_CYCLES = 16,
  parameter logic [WIDTH-1:0] RESET_VAL     = '0
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] switch,
  output logic             changed
`ifdef SWITCH_DEBOUNCE_EDGE_EN
  ,
  output logic [WIDTH-1:0] sw_rise
`endif
);

  localparam int               CNT_W    = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    SETTLING = 1'b1
  } filt_state_e;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_s;

  filt_state_e      state_q [WIDTH];
  filt_state_e      state_d [WIDTH];
  logic [CNT_W-1:0] cnt_q   [WIDTH];
  logic [CNT_W-1:0] cnt_d   [WIDTH];
  logic [WIDTH-1:0] switch_d;
  logic             changed_d;

  // Synchroniser chain; flops clear to RESET_VAL so no spurious settle after reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= RESET_VAL;
      end
    end else begin
      sync_q[0] <= sw_raw;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
      switch  <= RESET_VAL;
      changed <= 1'b0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      switch  <= switch_d;
      changed <= changed_d;
    end
  end

  // Per-bit filter: a bounce back to the current output discards the count.
  always_comb begin
    switch_d = switch;
    for (int i = 0; i < WIDTH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        IDLE: begin
          cnt_d[i] = '0;
          if (sync_s[i] != switch[i]) begin
            if (STABLE_CYCLES == 1) begin
              switch_d[i] = sync_s[i];
            end else begin
              state_d[i] = SETTLING;
              cnt_d[i]   = CNT_ONE;
            end
          end
        end
        SETTLING: begin
          if (sync_s[i] == switch[i]) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            switch_d[i] = sync_s[i];
            state_d[i]  = IDLE;
            cnt_d[i]    = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
    changed_d = |(switch_d ^ switch);
  end

`ifdef SWITCH_DEBOUNCE_EDGE_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sw_rise <= '0;
    end else begin
      sw_rise <= switch_d & ~switch;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_switch_debouncer.sv
// Self-checking bench for switch_debouncer (SYNC_STAGES=2, STABLE_CYCLES=4).
`default_nettype none

module tb_switch_debouncer;

  localparam int         WIDTH   = 4;
  localparam int         SYNC    = 2;
  localparam int         STABLE  = 4;
  localparam logic [3:0] RST_VAL = 4'h0;

  logic       clk = 1'b0;
  logic       n_rst;
  logic [3:0] sw_raw;
  logic [3:0] sw;
  logic       changed;
`ifdef SWITCH_DEBOUNCE_EDGE_EN
  logic [3:0] sw_rise;
`endif

  switch_debouncer #(
    .WIDTH         (WIDTH),
    .SYNC_STAGES   (SYNC),
    .STABLE_CYCLES (STABLE),
    .RESET_VAL     (RST_VAL)
  ) dut (
    .clk     (clk),
    .n_rst   (n_rst),
    .sw_raw  (sw_raw),
    .switch  (sw),
    .changed (changed)
`ifdef SWITCH_DEBOUNCE_EDGE_EN
    ,
    .sw_rise (sw_rise)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int pulses;

  // Reference model: history of raw samples since reset; a bit flips when the
  // synchronised value has differed from the output for STABLE consecutive edges.
  logic [3:0] raw_hist[$];
  int         n_edges;
  logic [3:0] m_sw;
  logic       m_chg;
  logic [3:0] m_rise;

  typedef struct {
    logic [3:0] raw;
    int         hold;
    logic [3:0] exp_sw;
    int         exp_pulses;
  } vec_t;
  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] s_at(input int k);
    if (k - SYNC >= 1) return raw_hist[k-SYNC-1];
    return RST_VAL;
  endfunction

  task automatic model_edge(input logic [3:0] raw);
    logic [3:0] nxt;
    logic [3:0] s;
    bit         all_diff;
    n_edges++;
    raw_hist.push_back(raw);
    nxt = m_sw;
    for (int b = 0; b < WIDTH; b++) begin
      if (n_edges >= STABLE) begin
        all_diff = 1'b1;
        for (int k = n_edges - STABLE + 1; k <= n_edges; k++) begin
          s = s_at(k);
          if (s[b] == m_sw[b]) all_diff = 1'b0;
        end
        if (all_diff) nxt[b] = ~m_sw[b];
      end
    end
    m_chg  = (nxt != m_sw);
    m_rise = nxt & ~m_sw;
    m_sw   = nxt;
  endtask

  task automatic model_reset();
    m_sw    = RST_VAL;
    m_chg   = 1'b0;
    m_rise  = '0;
    n_edges = 0;
    raw_hist.delete();
  endtask

  // One clock: model advances at the rising edge, outputs compared at the falling edge.
  task automatic tick();
    @(posedge clk);
    if (n_rst) model_edge(sw_raw);
    @(negedge clk);
    check("model_switch", sw, m_sw);
    check("model_changed", changed, m_chg);
`ifdef SWITCH_DEBOUNCE_EDGE_EN
    check("model_sw_rise", sw_rise, m_rise);
`endif
    if (changed) pulses++;
  endtask

  task automatic settle(input logic [3:0] v);
    sw_raw = v;
    repeat (8) tick();
  endtask

  initial begin
    vecs[0] = '{raw: 4'h5, hold: 56, exp_sw: 4'h5, exp_pulses: 1};
    vecs[1] = '{raw: 4'hA, hold: 3,  exp_sw: 4'h5, exp_pulses: 0};
    vecs[2] = '{raw: 4'h5, hold: 10, exp_sw: 4'h5, exp_pulses: 0};
    vecs[3] = '{raw: 4'hF, hold: 8,  exp_sw: 4'hF, exp_pulses: 1};
    vecs[4] = '{raw: 4'h0, hold: 8,  exp_sw: 4'h0, exp_pulses: 1};
    vecs[5] = '{raw: 4'h3, hold: 2,  exp_sw: 4'h0, exp_pulses: 0};
    vecs[6] = '{raw: 4'h0, hold: 8,  exp_sw: 4'h0, exp_pulses: 0};
    vecs[7] = '{raw: 4'hC, hold: 8,  exp_sw: 4'hC, exp_pulses: 1};
    vecs[8] = '{raw: 4'h0, hold: 8,  exp_sw: 4'h0, exp_pulses: 1};

    n_rst  = 1'b0;
    sw_raw = 4'h0;
    model_reset();
    @(negedge clk);

    // Reset hold, then release with all switches high.
    sw_raw = 4'hF;
    repeat (10) begin
      tick();
      check("rst_hold_switch", sw, 4'h0);
      check("rst_hold_changed", changed, 1'b0);
    end
    n_rst  = 1'b1;
    pulses = 0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      check("release_switch", sw, (e >= 6) ? 4'hF : 4'h0);
    end
    check("release_pulses", pulses, 1);
    settle(4'h0);

    // Table-driven steps.
    for (int v = 0; v < 9; v++) begin
      sw_raw = vecs[v].raw;
      pulses = 0;
      repeat (vecs[v].hold) tick();
      check("vec_switch", sw, vecs[v].exp_sw);
      check("vec_pulses", pulses, vecs[v].exp_pulses);
    end

    // Bounce on bit 0 at 2-cycle spacing, then held high.
    pulses = 0;
    for (int j = 0; j < 4; j++) begin
      sw_raw = (j % 2 == 0) ? 4'h1 : 4'h0;
      repeat (2) begin
        tick();
        check("bounce_hold", sw, 4'h0);
      end
    end
    sw_raw = 4'h1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      check("bounce_final", sw, (e >= 6) ? 4'h1 : 4'h0);
    end
    check("bounce_pulses", pulses, 1);
    settle(4'h0);

    // Independent bits settling on different edges.
    pulses = 0;
    sw_raw = 4'h1;
    tick();
    tick();
    sw_raw = 4'h5;
    for (int e = 3; e <= 9; e++) begin
      tick();
      check("indep_switch", sw, (e < 6) ? 4'h0 : ((e < 8) ? 4'h1 : 4'h5));
    end
    check("indep_pulses", pulses, 2);

    // Reset asserted mid-settle clears the output without a clock edge.
    settle(4'hC);
    sw_raw = 4'h3;
    repeat (3) tick();
    n_rst = 1'b0;
    model_reset();
    #1;
    check("midrst_switch", sw, 4'h0);
    check("midrst_changed", changed, 1'b0);
    @(negedge clk);
    repeat (2) tick();
    n_rst = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      check("midrst_release", sw, (e >= 6) ? 4'h3 : 4'h0);
    end

`ifdef SWITCH_DEBOUNCE_EDGE_EN
    settle(4'h3);
    sw_raw = 4'h6;
    for (int e = 1; e <= 7; e++) begin
      tick();
      check("rise_bits", sw_rise, (e == 6) ? 4'h4 : 4'h0);
      check("rise_changed", changed, (e == 6) ? 1'b1 : 1'b0);
    end
`endif

    // Random glitchy stimulus against the model, with one reset in the middle.
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 7))
        0:       sw_raw = 4'($urandom_range(0, 15));
        1, 2:    sw_raw = sw_raw ^ (4'h1 << $urandom_range(0, 3));
        default: sw_raw = sw_raw;
      endcase
      if (i == 300) begin
        n_rst = 1'b0;
        model_reset();
        #1;
        check("rand_rst_switch", sw, RST_VAL);
        @(negedge clk);
        repeat (2) tick();
        n_rst = 1'b1;
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
